// File: rtl/money_pkg.sv
// Shared key codes, money limits, keypad map and scanner state type for the
// keypad-to-display money path.
package money_pkg;

    localparam logic [3:0] KEY_STAR  = 4'd14;
    localparam logic [3:0] KEY_HASH  = 4'd15;
    // Scan-result sentinel; one bit wider than any real key code.
    localparam logic [4:0] KEY_NONE  = 5'd16;
    localparam int         MONEY_MAX = 10000;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        PRESSED
    } key_state_t;

    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = KEY_STAR;
            4'hD: code = 4'd0;
            4'hE: code = KEY_HASH;
            default: code = 4'd13;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner.sv
// Column-scans a 4x4 active-low keypad, reduces each full scan to a single key
// or none, and debounces that result into a one-cycle key strobe.
module keypad_scanner
    import money_pkg::*;
#(
    parameter int SCAN_DIV       = 2000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_pulse
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [3:0]       row_meta_reg;
    logic [3:0]       row_sync_reg;
    logic [DIV_W-1:0] div_reg;
    logic [1:0]       col_idx_reg;
    logic [3:0]       col_n_reg;
    logic [1:0]       hits_reg;
    logic [3:0]       hit_code_reg;
    key_state_t       state_reg;
    logic [3:0]       cand_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [3:0]       key_code_reg;
    logic             key_pulse_reg;

    logic [3:0] row_code [4];
    logic [2:0] col_hits;
    logic [3:0] col_code;
    logic [2:0] hit_sum;
    logic [1:0] scan_hits_next;
    logic [3:0] scan_code_next;
    logic [4:0] scan_result;
    logic       sample_tick;
    logic       scan_end;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_row_code
            assign row_code[gi] = keymap(2'(gi), col_idx_reg);
        end
    endgenerate

    assign sample_tick = (div_reg == DIV_W'(SCAN_DIV - 1));
    assign scan_end    = sample_tick && (col_idx_reg == 2'd3);

    // Hits saturate at 2: anything beyond one key in a scan is simply "many".
    always_comb begin
        col_hits = 3'd0;
        col_code = 4'd0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_reg[r]) begin
                col_hits = col_hits + 3'd1;
                col_code = row_code[r];
            end
        end
        hit_sum        = {1'b0, hits_reg} + col_hits;
        scan_hits_next = (hit_sum > 3'd2) ? 2'd2 : hit_sum[1:0];
        scan_code_next = (hits_reg == 2'd0) ? col_code : hit_code_reg;
        scan_result    = (scan_hits_next == 2'd1) ? {1'b0, scan_code_next} : KEY_NONE;
    end

    always_ff @(posedge clk) begin
        key_pulse_reg <= 1'b0;
        if (rst) begin
            row_meta_reg <= 4'hF;
            row_sync_reg <= 4'hF;
            div_reg      <= '0;
            col_idx_reg  <= 2'd0;
            col_n_reg    <= 4'b1110;
            hits_reg     <= 2'd0;
            hit_code_reg <= 4'd0;
            state_reg    <= IDLE;
            cand_reg     <= 4'd0;
            cnt_reg      <= '0;
            key_code_reg <= 4'd0;
        end else begin
            row_meta_reg <= row_n;
            row_sync_reg <= row_meta_reg;
            if (!sample_tick) begin
                div_reg <= div_reg + DIV_W'(1);
            end else begin
                div_reg     <= '0;
                col_idx_reg <= col_idx_reg + 2'd1;
                col_n_reg   <= {col_n_reg[2:0], col_n_reg[3]};
                if (scan_end) begin
                    hits_reg     <= 2'd0;
                    hit_code_reg <= 4'd0;
                    case (state_reg)
                        IDLE: begin
                            if (scan_result != KEY_NONE) begin
                                cand_reg <= scan_result[3:0];
                                if (DEBOUNCE_SCANS <= 1) begin
                                    state_reg     <= PRESSED;
                                    key_pulse_reg <= 1'b1;
                                    key_code_reg  <= scan_result[3:0];
                                    cnt_reg       <= '0;
                                end else begin
                                    state_reg <= DEBOUNCE;
                                    cnt_reg   <= CNT_W'(1);
                                end
                            end
                        end
                        DEBOUNCE: begin
                            if (scan_result != {1'b0, cand_reg}) begin
                                state_reg <= IDLE;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                state_reg     <= PRESSED;
                                key_pulse_reg <= 1'b1;
                                key_code_reg  <= cand_reg;
                                cnt_reg       <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        PRESSED: begin
                            // Release needs a run of empty scans; any key activity restarts it.
                            if (scan_result != KEY_NONE) begin
                                cnt_reg <= '0;
                            end else if (cnt_reg == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                                state_reg <= IDLE;
                                cnt_reg   <= '0;
                            end else begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end
                        end
                        default: begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                        end
                    endcase
                end else begin
                    hits_reg     <= scan_hits_next;
                    hit_code_reg <= scan_code_next;
                end
            end
        end
    end

    assign col_n     = col_n_reg;
    assign key_code  = key_code_reg;
    assign key_pulse = key_pulse_reg;

endmodule

// File: rtl/keypad_money_entry.sv
// Keypad front end of the money path: turns debounced key strobes into a
// clamped decimal amount and commits it to entered_value on '#'.
module keypad_money_entry
    import money_pkg::*;
#(
    parameter int SCAN_DIV       = 2000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int MAX_VALUE      = MONEY_MAX,
    parameter int MAX_DIGITS     = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_pulse,
    output logic [15:0] value,
    output logic [2:0]  digit_count,
    output logic [15:0] entered_value,
    output logic        value_valid
);

    logic [15:0] value_reg;
    logic [2:0]  digit_count_reg;
    logic [15:0] entered_value_reg;
    logic        value_valid_reg;
    logic [16:0] digit_sum;
    logic [15:0] digit_clamped;
    logic        leading_zero;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_pulse (key_pulse)
    );

    // 17 bits holds the worst case 10000*10+9 before clamping.
    always_comb begin
        digit_sum     = {1'b0, value_reg} * 17'd10 + {13'd0, key_code};
        digit_clamped = (digit_sum > 17'(MAX_VALUE)) ? 16'(MAX_VALUE) : digit_sum[15:0];
        leading_zero  = (value_reg == 16'd0) && (key_code == 4'd0);
    end

    always_ff @(posedge clk) begin
        value_valid_reg <= 1'b0;
        if (rst) begin
            value_reg         <= 16'd0;
            digit_count_reg   <= 3'd0;
            entered_value_reg <= 16'd0;
        end else if (key_pulse) begin
            if (key_code < 4'd10) begin
                if (!leading_zero && (digit_count_reg < 3'(MAX_DIGITS))) begin
                    value_reg       <= digit_clamped;
                    digit_count_reg <= digit_count_reg + 3'd1;
                end
            end else if (key_code == KEY_STAR) begin
                value_reg       <= 16'd0;
                digit_count_reg <= 3'd0;
            end else if (key_code == KEY_HASH) begin
                entered_value_reg <= value_reg;
                value_valid_reg   <= 1'b1;
                value_reg         <= 16'd0;
                digit_count_reg   <= 3'd0;
            end
        end
    end

    assign value         = value_reg;
    assign digit_count   = digit_count_reg;
    assign entered_value = entered_value_reg;
    assign value_valid   = value_valid_reg;

endmodule

// File: tb/tb_keypad_money_entry.sv
// Emulates a physical keypad around keypad_money_entry, predicts each key
// strobe and its effect on the amount, and checks them from a separate monitor.
module tb_keypad_money_entry;

    localparam int SD   = 4;
    localparam int DS   = 2;
    localparam int SCAN = 4 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_pulse;
    logic [15:0] value;
    logic [2:0]  digit_count;
    logic [15:0] entered_value;
    logic        value_valid;

    logic [15:0] held_mask = 16'h0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int code;
        int val;
        int cnt;
        bit commit;
        int entered;
    } exp_t;

    exp_t exp_q[$];
    int   m_val = 0;
    int   m_cnt = 0;

    // Key at row r, column c lives at index r*4+c.
    int keytab [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};

    keypad_money_entry #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .row_n         (row_n),
        .col_n         (col_n),
        .key_code      (key_code),
        .key_pulse     (key_pulse),
        .value         (value),
        .digit_count   (digit_count),
        .entered_value (entered_value),
        .value_valid   (value_valid)
    );

    always #5 clk = ~clk;

    // A held key pulls its row low only while its column is driven low.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (held_mask[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int pos_of(input int code);
        for (int i = 0; i < 16; i++)
            if (keytab[i] == code) return i;
        return 0;
    endfunction

    // Reference behaviour of one accepted key on the amount being typed.
    task automatic model_key(input int code);
        exp_t e;
        e.code = code;
        e.commit = 0;
        e.entered = 0;
        if (code < 10) begin
            if (!(m_val == 0 && code == 0) && m_cnt < 5) begin
                m_val = (m_val * 10 + code > 10000) ? 10000 : m_val * 10 + code;
                m_cnt = m_cnt + 1;
            end
        end else if (code == 14) begin
            m_val = 0;
            m_cnt = 0;
        end else if (code == 15) begin
            e.commit = 1;
            e.entered = m_val;
            m_val = 0;
            m_cnt = 0;
        end
        e.val = m_val;
        e.cnt = m_cnt;
        exp_q.push_back(e);
    endtask

    task automatic press(input int code, input int hold_scans, input int rel_scans, input bit expect_pulse);
        if (expect_pulse) model_key(code);
        held_mask[pos_of(code)] = 1'b1;
        repeat (hold_scans * SCAN) @(negedge clk);
        held_mask = 16'h0;
        repeat (rel_scans * SCAN) @(negedge clk);
    endtask

    // Monitor: pops one expectation per key strobe, checks the amount one cycle later.
    initial begin
        bit   pend;
        exp_t cur;
        pend = 0;
        forever begin
            @(negedge clk);
            if (pend) begin
                pend = 0;
                chk("value", int'(value), cur.val);
                chk("digit_count", int'(digit_count), cur.cnt);
                chk("value_valid", int'(value_valid), int'(cur.commit));
                if (cur.commit) chk("entered_value", int'(entered_value), cur.entered);
            end else if (value_valid) begin
                chk("unexpected_value_valid", 1, 0);
            end
            if (key_pulse) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_key_pulse", int'(key_code), -1);
                end else begin
                    cur = exp_q.pop_front();
                    chk("key_code", int'(key_code), cur.code);
                    $display("key pulse code=%0d expect value=%0d count=%0d commit=%0d",
                             key_code, cur.val, cur.cnt, cur.commit);
                    pend = 1;
                end
            end
        end
    end

    initial begin
        int  code;
        int  k;
        bit  seen;

        // Reset state and column rotation.
        repeat (3) @(negedge clk);
        chk("rst_col_n", int'(col_n), 4'b1110);
        chk("rst_key_code", int'(key_code), 0);
        chk("rst_key_pulse", int'(key_pulse), 0);
        chk("rst_value", int'(value), 0);
        chk("rst_digit_count", int'(digit_count), 0);
        chk("rst_entered", int'(entered_value), 0);
        chk("rst_value_valid", int'(value_valid), 0);
        rst = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk);
            #1;
            chk("col_step", int'(col_n), int'(~(4'b0001 << ((i / SD) % 4)) & 4'hF));
        end
        @(negedge clk);

        // 1,2,3,4 then commit.
        press(1, 3, 3, 1);
        press(2, 3, 3, 1);
        press(3, 3, 3, 1);
        press(4, 3, 3, 1);
        press(15, 3, 3, 1);

        // Clamp and digit limit.
        for (int i = 0; i < 5; i++) press(9, 3, 3, 1);
        press(7, 3, 3, 1);
        press(15, 3, 3, 1);

        // Bounce, then a long hold.
        press(5, 1, 3, 0);
        press(5, 20, 3, 1);

        // Clear, two keys together, leading zero.
        press(5, 3, 3, 1);
        press(6, 3, 3, 1);
        press(14, 3, 3, 1);
        held_mask[pos_of(2)] = 1'b1;
        held_mask[pos_of(3)] = 1'b1;
        repeat (3 * SCAN) @(negedge clk);
        held_mask = 16'h0;
        repeat (3 * SCAN) @(negedge clk);
        press(0, 3, 3, 1);

        // Random keys with random phase and timing.
        for (int i = 0; i < 30; i++) begin
            code = $urandom_range(0, 15);
            repeat ($urandom_range(0, SCAN - 1)) @(negedge clk);
            press(code, $urandom_range(3, 5), $urandom_range(3, 5), 1);
        end
        press(7, 3, 3, 1);

        // Reset while key 8 is being debounced.
        seen = 0;
        k = 0;
        while (!(seen && col_n == 4'b1110) && k < 8 * SCAN) begin
            @(negedge clk);
            if (col_n == 4'b0111) seen = 1;
            k++;
        end
        chk("scan_align_timeout", int'(k < 8 * SCAN), 1);
        held_mask[pos_of(8)] = 1'b1;
        repeat (SCAN + SCAN / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_col_n", int'(col_n), 4'b1110);
        chk("mid_rst_key_code", int'(key_code), 0);
        chk("mid_rst_key_pulse", int'(key_pulse), 0);
        chk("mid_rst_value", int'(value), 0);
        chk("mid_rst_digit_count", int'(digit_count), 0);
        chk("mid_rst_entered", int'(entered_value), 0);
        chk("mid_rst_value_valid", int'(value_valid), 0);
        m_val = 0;
        m_cnt = 0;
        model_key(8);
        repeat (4 * SCAN) @(negedge clk);
        held_mask = 16'h0;
        repeat (3 * SCAN) @(negedge clk);

        chk("pending_pulses", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
